exhaustive_sweep_checker: RTL and testbench

//  Synthesizable self-checking engine for small combinational blocks.

---
 rtl/sweep_pkg.sv | 24 ++
 rtl/sweep_delay_line.sv | 47 ++++
 rtl/exhaustive_sweep_checker.sv | 202 ++++++++++++++++++++
 tb/tb_exhaustive_sweep_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and helpers for the exhaustive sweep checker.
// Holds the FSM state enum, the MISR polynomial and a saturating increment.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  // Increments count, holding at 2**width-1.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] count,
    input int          width
  );
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (count >= max_v) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/sweep_delay_line.sv
// sweep_delay_line: DEPTH-stage shift register, pass-through when DEPTH==0.
// Ports: clk, reset_n (sync, active-low), d[W] in, q[W] out.
module sweep_delay_line
  import sweep_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] pipe_q [DEPTH];
      logic [W-1:0] pipe_d [DEPTH];

      always_comb begin
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// exhaustive_sweep_checker: sweeps all N_IN-bit vectors, compares resp vs exp.
// Ports: clk, reset_n (sync, active-low), start in; stim out to DUT/golden;
//   resp/exp in (DUT_LAT aligned); busy, done, pass, err_count,
//   first_fail_vld, first_fail_vec out. Optional sig[15:0] MISR output
//   when SWEEP_SIGNATURE_EN is defined.
module exhaustive_sweep_checker
  import sweep_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int N_OUT   = 1,
  parameter int DUT_LAT = 0,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  input  logic [N_OUT-1:0]  exp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_vld,
  output logic [N_IN-1:0]   first_fail_vec
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]       sig
`endif
);

  localparam int DW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;
  logic [DW-1:0]     drain_q, drain_d;

  logic              drive_vld;
  logic [N_IN:0]     dly_q;
  logic              strobe;
  logic [N_IN-1:0]   cmp_idx;
  logic              mismatch;
  logic              launch;
  logic              finish;

  // Valid flag and vector index travel together so each compare
  // knows which vector produced the response it is checking.
  assign drive_vld = (state_q == DRIVE);

  sweep_delay_line #(
    .W     (N_IN + 1),
    .DEPTH (DUT_LAT)
  ) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({drive_vld, stim_q}),
    .q       (dly_q)
  );

  assign strobe  = dly_q[N_IN];
  assign cmp_idx = dly_q[N_IN-1:0];

`ifdef SWEEP_SIGNATURE_EN
  localparam int RW = (N_OUT < 16) ? N_OUT : 16;
  logic [15:0] sig_q, sig_d;
  logic [15:0] resp_ext;
  assign resp_ext = 16'(resp[RW-1:0]);
`endif

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    drain_d  = drain_q;
    launch   = 1'b0;
    finish   = 1'b0;
`ifdef SWEEP_SIGNATURE_EN
    sig_d    = sig_q;
`endif

    mismatch = strobe && (resp != exp);
    if (mismatch) begin
      err_d = ERR_W'(sat_inc(32'(err_q), ERR_W));
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = cmp_idx;
      end
    end

`ifdef SWEEP_SIGNATURE_EN
    if (strobe) begin
      sig_d = {sig_q[14:0], 1'b0}
            ^ (sig_q[15] ? MISR_POLY : 16'h0000)
            ^ resp_ext;
    end
`endif

    unique case (state_q)
      IDLE: launch = start;
      DRIVE: begin
        if (stim_q == STIM_LAST) begin
          if (DUT_LAT > 0) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            finish = 1'b1;
          end
        end else begin
          stim_d = stim_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          finish = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: launch = start;
      default: state_d = IDLE;
    endcase

    // pass reflects the count including this cycle's final compare.
    if (finish) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == '0);
    end

    if (launch) begin
      state_d = DRIVE;
      stim_d  = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      err_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
      drain_d = '0;
`ifdef SWEEP_SIGNATURE_EN
      sig_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      drain_q <= '0;
`ifdef SWEEP_SIGNATURE_EN
      sig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      drain_q <= drain_d;
`ifdef SWEEP_SIGNATURE_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;
`ifdef SWEEP_SIGNATURE_EN
  assign sig            = sig_q;
`endif

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// tb_exhaustive_sweep_checker: two checker instances (latency 0 / 2) driven
// by table-based DUT models with random truth tables and fault masks.
module tb_exhaustive_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start;
  logic [7:0] tt;
  logic [7:0] flt0;
  logic [7:0] flt1;
  logic       skew;

  logic [2:0] stim0, ffvec0;
  logic       busy0, done0, pass0, ffv0;
  logic [7:0] err0;
  logic       resp0, exp0;

  logic [2:0] stim1, ffvec1;
  logic       busy1, done1, pass1, ffv1;
  logic [1:0] err1;
  logic       resp1, exp1;
  logic       e1, e2, r1, r2, r3;

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] sig0, sig1;
`endif

  assign exp0  = tt[stim0];
  assign resp0 = tt[stim0] ^ flt0[stim0];

  // Golden model and DUT both registered twice; skew adds one stage to resp.
  always @(posedge clk) begin
    e1 <= tt[stim1];
    e2 <= e1;
    r1 <= tt[stim1] ^ flt1[stim1];
    r2 <= r1;
    r3 <= r2;
  end
  assign exp1  = e2;
  assign resp1 = skew ? r3 : r2;

  exhaustive_sweep_checker #(
    .N_IN(3), .N_OUT(1), .DUT_LAT(0), .ERR_W(8)
  ) u0 (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stim           (stim0),
    .resp           (resp0),
    .exp            (exp0),
    .busy           (busy0),
    .done           (done0),
    .pass           (pass0),
    .err_count      (err0),
    .first_fail_vld (ffv0),
    .first_fail_vec (ffvec0)
`ifdef SWEEP_SIGNATURE_EN
    ,
    .sig            (sig0)
`endif
  );

  exhaustive_sweep_checker #(
    .N_IN(3), .N_OUT(1), .DUT_LAT(2), .ERR_W(2)
  ) u1 (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stim           (stim1),
    .resp           (resp1),
    .exp            (exp1),
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
    .err_count      (err1),
    .first_fail_vld (ffv1),
    .first_fail_vec (ffvec1)
`ifdef SWEEP_SIGNATURE_EN
    ,
    .sig            (sig1)
`endif
  );

  int passes = 0;
  int total  = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int popc(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic int first_set(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] misr_of(
    input logic [7:0] t,
    input logic [7:0] f
  );
    logic [15:0] s = 16'h0;
    for (int v = 0; v < 8; v++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ 16'(t[v] ^ f[v]);
    end
    return s;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "/stim0"}, stim0, 0);
    check({tag, "/busy0"}, busy0, 0);
    check({tag, "/done0"}, done0, 0);
    check({tag, "/pass0"}, pass0, 0);
    check({tag, "/err0"},  err0,  0);
    check({tag, "/ffv0"},  ffv0,  0);
    check({tag, "/ffvec0"}, ffvec0, 0);
    check({tag, "/stim1"}, stim1, 0);
    check({tag, "/busy1"}, busy1, 0);
    check({tag, "/done1"}, done1, 0);
    check({tag, "/err1"},  err1,  0);
    check({tag, "/ffv1"},  ffv1,  0);
  endtask

  task automatic run_sweep(input string tag, input bit mid_start);
    int k0 = 0;
    int bc1 = 0;
    int seq_bad = 0;
    bit did = 0;
    int n0 = popc(flt0);
    int n1 = popc(flt1);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) begin
        check({tag, "/clr_busy0"}, busy0, 1);
        check({tag, "/clr_done0"}, done0, 0);
        check({tag, "/clr_err0"},  err0,  0);
        check({tag, "/clr_ffv0"},  ffv0,  0);
        check({tag, "/clr_done1"}, done1, 0);
        check({tag, "/clr_err1"},  err1,  0);
      end
      if (mid_start && !did && busy0 && stim0 == 3'd3) begin
        start = 1'b1;
        did = 1'b1;
      end
      if (busy0) begin
        if (stim0 != k0[2:0]) seq_bad++;
        k0++;
      end
      if (busy1) bc1++;
    end
    check({tag, "/busy0_cycles"}, k0, 8);
    check({tag, "/stim0_seq_bad"}, seq_bad, 0);
    check({tag, "/stim0_hold"}, stim0, 7);
    check({tag, "/done0"}, done0, 1);
    check({tag, "/pass0"}, pass0, (n0 == 0) ? 1 : 0);
    check({tag, "/err0"},  err0,  n0);
    check({tag, "/ffv0"},  ffv0,  (n0 != 0) ? 1 : 0);
    if (n0 != 0) check({tag, "/ffvec0"}, ffvec0, first_set(flt0));
    check({tag, "/busy1_cycles"}, bc1, 10);
    check({tag, "/done1"}, done1, 1);
`ifdef SWEEP_SIGNATURE_EN
    check({tag, "/sig0"}, sig0, misr_of(tt, flt0));
`endif
    if (skew) begin
      check({tag, "/skew_err1"},  err1,  3);
      check({tag, "/skew_pass1"}, pass1, 0);
    end else begin
      check({tag, "/pass1"}, pass1, (n1 == 0) ? 1 : 0);
      check({tag, "/err1"},  err1,  imin(n1, 3));
      check({tag, "/ffv1"},  ffv1,  (n1 != 0) ? 1 : 0);
      if (n1 != 0) check({tag, "/ffvec1"}, ffvec1, first_set(flt1));
`ifdef SWEEP_SIGNATURE_EN
      check({tag, "/sig1"}, sig1, misr_of(tt, flt1));
`endif
    end
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    start   = 1'b0;
    tt      = 8'h00;
    flt0    = 8'h00;
    flt1    = 8'h00;
    skew    = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    tt = 8'($urandom);
    run_sweep("clean", 1'b0);

    flt0 = 8'b0010_0000;
    flt1 = 8'b0010_0000;
    run_sweep("fault5", 1'b0);

    flt0 = 8'hFF;
    flt1 = 8'hFF;
    run_sweep("allbad", 1'b0);

    flt0 = 8'h00;
    flt1 = 8'h00;
    tt   = 8'hAA;
    skew = 1'b1;
    run_sweep("skew", 1'b0);
    skew = 1'b0;

    tt   = 8'($urandom);
    flt0 = 8'($urandom & $urandom);
    flt1 = 8'($urandom & $urandom);
    run_sweep("midstart", 1'b1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (stim0 == 3'd4) found = 1'b1;
      else @(negedge clk);
    end
    check("midreset/reach4", found, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    reset_n = 1'b1;
    run_sweep("after_reset", 1'b0);

    for (int r = 0; r < 6; r++) begin
      tt   = 8'($urandom);
      flt0 = 8'($urandom & $urandom & $urandom);
      flt1 = 8'($urandom & $urandom & $urandom);
      run_sweep($sformatf("rand%0d", r), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
